scale_report_tx: RTL

- Transmit end of the smart-scale result path. Captures one classification result set from the smart-scales system on a start strobe and sends it off-chip as a 4-byte UART frame (8N1).
- Sits between the combinational smart-scales system outputs and the display/host serial link.
- Holds its captured snapshot for the whole frame, so upstream inputs may change freely after capture.

---
 rtl/scale_report_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/scale_report_tx.sv
// scale_report_tx: captures one smart-scales result set on a start strobe and
// sends it as a 4-byte 8N1 UART frame: HEADER, range, flags, checksum.
// The snapshot is held for the whole frame so upstream inputs may change freely.
module scale_report_tx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] range,
    input  logic       overweight,
    input  logic       normal_bmi,
    input  logic       underweight,
    input  logic       normal,
    input  logic       abnormal,
    input  logic       type_tob,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    snap_range;
    logic [7:0]    snap_flags;
    logic [7:0]    snap_sum;

    logic          baud_end;
    logic          accept;
    logic          bmi_onehot;
    logic          err;
    logic [7:0]    flags_in;
    logic [7:0]    sum_in;
    logic [7:0]    cur_byte;

    assign baud_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    // Start requests are only honoured while idle, so busy gates them out.
    assign accept   = (state == IDLE) && start;

    // Exactly one BMI class must be set, and the BMD flags must disagree.
    assign bmi_onehot = ( overweight & ~normal_bmi & ~underweight) |
                        (~overweight &  normal_bmi & ~underweight) |
                        (~overweight & ~normal_bmi &  underweight);
    assign err      = ~bmi_onehot | (normal == abnormal);
    assign flags_in = {1'b0, err, type_tob, abnormal, normal,
                       underweight, normal_bmi, overweight};
    // 8-bit sum; carries fall off the top by construction.
    assign sum_in   = HEADER + range + flags_in;

    // Select the byte currently on the wire from the held snapshot.
    always_comb begin
        cur_byte = HEADER;
        case (byte_idx)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = snap_range;
            2'd2:    cur_byte = snap_flags;
            default: cur_byte = snap_sum;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: each non-idle state lasts whole bit periods.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = START;
            START:   if (baud_end) state_next = DATA;
            DATA:    if (baud_end && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (baud_end) state_next = (byte_idx == 2'd3) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: line level and busy follow the state directly.
    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            START:   tx   = 1'b0;
            DATA:    tx   = cur_byte[bit_idx];
            STOP:    tx   = 1'b1;
            default: begin
                tx   = 1'b1;
                busy = 1'b0;
            end
        endcase
    end

    // Baud, bit and byte counters plus the one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == STOP) && baud_end && (byte_idx == 2'd3);
            if (state == IDLE) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                byte_idx <= '0;
            end else begin
                baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
                if (state == DATA && baud_end) bit_idx  <= bit_idx + 1'b1;
                if (state == STOP && baud_end) byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    // Snapshot of the result set, taken only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_range <= '0;
            snap_flags <= '0;
            snap_sum   <= '0;
        end else if (accept) begin
            snap_range <= range;
            snap_flags <= flags_in;
            snap_sum   <= sum_in;
        end
    end

endmodule
